// File: rtl/result_bram_wr_arbiter_if.sv
// Result BRAM write-arbiter bus: two requester handshakes plus
// the BRAM write port that the arbiter drives.
interface result_bram_wr_arbiter_if #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 9
);
   logic              i_req0_valid;
   logic              o_req0_ready;
   logic [7:0]        i_req0_idx;
   logic [DATA_W-1:0] i_req0_data;
   logic              i_req1_valid;
   logic              o_req1_ready;
   logic [7:0]        i_req1_idx;
   logic [DATA_W-1:0] i_req1_data;
   logic              o_bram_wr_en;
   logic [ADDR_W-1:0] o_bram_wr_addr;
   logic [DATA_W-1:0] o_bram_wr_data;

   modport slave (
      input  i_req0_valid, i_req0_idx, i_req0_data,
      input  i_req1_valid, i_req1_idx, i_req1_data,
      output o_req0_ready, o_req1_ready,
      output o_bram_wr_en, o_bram_wr_addr, o_bram_wr_data
   );

   modport master (
      output i_req0_valid, i_req0_idx, i_req0_data,
      output i_req1_valid, i_req1_idx, i_req1_data,
      input  o_req0_ready, o_req1_ready,
      input  o_bram_wr_en, o_bram_wr_addr, o_bram_wr_data
   );
endinterface

// File: rtl/result_bram_wr_arbiter.sv
// Round-robin write arbiter for the result BRAM with a
// full-memory zero-fill mode.
module result_bram_wr_arbiter #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 9
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   result_bram_wr_arbiter_if.slave  bus,
   input  logic                     i_clear_start,
   output logic                     o_clear_busy,
   output logic                     o_clear_done,
   output logic [8:0]               o_wr_count0,
   output logic [8:0]               o_wr_count1
);

   typedef enum logic {
      ARB   = 1'b0,
      CLEAR = 1'b1
   } state_e;

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [8:0]        CNT_MAX   = 9'h1FF;

   state_e            state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [8:0]        cnt0_q, cnt0_d;
   logic [8:0]        cnt1_q, cnt1_d;

   logic arb_ok;
   logic grant0;
   logic grant1;
   logic acc0;
   logic acc1;

   // ptr_q == 0 favours requester 0 when both are valid
   assign grant0 = bus.i_req0_valid &
                   (~bus.i_req1_valid | ~ptr_q);
   assign grant1 = bus.i_req1_valid &
                   (~bus.i_req0_valid | ptr_q);

   assign arb_ok = (state_q == ARB) & ~i_clear_start &
                   ~i_reset;
   assign acc0   = arb_ok & grant0;
   assign acc1   = arb_ok & grant1;

   assign bus.o_req0_ready   = acc0;
   assign bus.o_req1_ready   = acc1;
   assign bus.o_bram_wr_en   = wr_en_q;
   assign bus.o_bram_wr_addr = wr_addr_q;
   assign bus.o_bram_wr_data = wr_data_q;
   assign o_clear_busy       = busy_q;
   assign o_clear_done       = done_q;
   assign o_wr_count0        = cnt0_q;
   assign o_wr_count1        = cnt1_q;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      cnt0_d    = cnt0_q;
      cnt1_d    = cnt1_q;
      unique case (state_q)
         ARB: begin
            if (i_clear_start) begin
               state_d   = CLEAR;
               busy_d    = 1'b1;
               cnt0_d    = '0;
               cnt1_d    = '0;
               wr_en_d   = 1'b1;
               wr_addr_d = '0;
               wr_data_d = '0;
            end else if (acc0) begin
               ptr_d     = 1'b1;
               wr_en_d   = 1'b1;
               wr_addr_d = ADDR_W'({1'b0, bus.i_req0_idx});
               wr_data_d = bus.i_req0_data;
               if (cnt0_q != CNT_MAX)
                  cnt0_d = cnt0_q + 9'd1;
            end else if (acc1) begin
               ptr_d     = 1'b0;
               wr_en_d   = 1'b1;
               wr_addr_d = ADDR_W'({1'b1, bus.i_req1_idx});
               wr_data_d = bus.i_req1_data;
               if (cnt1_q != CNT_MAX)
                  cnt1_d = cnt1_q + 9'd1;
            end
         end
         CLEAR: begin
            // wr_addr_q always holds the line just zeroed
            if (wr_addr_q == LAST_ADDR) begin
               state_d = ARB;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = wr_addr_q + 1'b1;
               wr_data_d = '0;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= ARB;
         ptr_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt0_q    <= '0;
         cnt1_q    <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cnt0_q    <= cnt0_d;
         cnt1_q    <= cnt1_d;
      end
   end

endmodule

// File: tb/tb_result_bram_wr_arbiter.sv
// Directed bench for result_bram_wr_arbiter with a write
// scoreboard fed by the stimulus and drained by a monitor.
module tb_result_bram_wr_arbiter;
   localparam int DW = 256;
   localparam int AW = 9;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;
   logic       busy;
   logic       done;
   logic [8:0] c0;
   logic [8:0] c1;

   always #5 clk = ~clk;

   result_bram_wr_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();

   result_bram_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .bus           (bif),
      .i_clear_start (clr),
      .o_clear_busy  (busy),
      .o_clear_done  (done),
      .o_wr_count0   (c0),
      .o_wr_count1   (c1)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t sb[$];
   wr_t mon_e;
   int  n_tests = 0;
   int  n_fail  = 0;

   function automatic logic [DW-1:0] pat(input int k);
      return {8{32'h5A5A_0000 ^ 32'(k)}};
   endfunction

   task automatic chk(input string tag,
                      input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bif.o_bram_wr_en === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL wr_unexpected: observed addr %0h expected no write",
                   bif.o_bram_wr_addr);
         end else begin
            mon_e = sb.pop_front();
            chk("wr_addr", DW'(bif.o_bram_wr_addr), DW'(mon_e.a));
            chk("wr_data", bif.o_bram_wr_data, mon_e.d);
         end
      end
   end

   task automatic cyc(input logic v0, input logic [7:0] i0,
                      input logic [DW-1:0] d0,
                      input logic v1, input logic [7:0] i1,
                      input logic [DW-1:0] d1,
                      input logic c, input logic r,
                      input logic er0, input logic er1);
      @(posedge clk);
      #1;
      bif.i_req0_valid = v0;
      bif.i_req0_idx   = i0;
      bif.i_req0_data  = d0;
      bif.i_req1_valid = v1;
      bif.i_req1_idx   = i1;
      bif.i_req1_data  = d1;
      clr = c;
      rst = r;
      @(negedge clk);
      #1;
      chk("ready0", DW'(bif.o_req0_ready), DW'(er0));
      chk("ready1", DW'(bif.o_req1_ready), DW'(er1));
      if (er0) sb.push_back('{{1'b0, i0}, d0});
      if (er1) sb.push_back('{{1'b1, i1}, d1});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         cyc(0, 8'h0, '0, 0, 8'h0, '0, 0, 0, 0, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      clr = 1'b0;
      bif.i_req0_valid = 1'b0;
      bif.i_req0_idx   = '0;
      bif.i_req0_data  = '0;
      bif.i_req1_valid = 1'b0;
      bif.i_req1_idx   = '0;
      bif.i_req1_data  = '0;

      // readies must stay low while reset is held
      cyc(1, 8'h05, pat(1), 1, 8'h01, pat(2), 0, 1, 0, 0);
      cyc(1, 8'h05, pat(1), 1, 8'h01, pat(2), 0, 1, 0, 0);
      chk("rst_wr_en", DW'(bif.o_bram_wr_en), '0);
      chk("rst_addr", DW'(bif.o_bram_wr_addr), '0);
      chk("rst_data", bif.o_bram_wr_data, '0);
      chk("rst_busy", DW'(busy), '0);
      chk("rst_done", DW'(done), '0);
      chk("rst_cnt0", DW'(c0), '0);
      chk("rst_cnt1", DW'(c1), '0);

      cyc(1, 8'h05, pat(5), 0, 8'h0, '0, 0, 0, 1, 0);
      idle(1);
      chk("single_cnt0", DW'(c0), DW'(1));
      chk("single_cnt1", DW'(c1), DW'(0));

      cyc(0, 8'h0, '0, 1, 8'h22, pat(6), 0, 0, 0, 1);
      idle(1);
      chk("single_cnt1", DW'(c1), DW'(1));

      cyc(1, 8'h00, pat(10), 1, 8'h00, pat(20), 0, 0, 1, 0);
      cyc(1, 8'h01, pat(11), 1, 8'h00, pat(20), 0, 0, 0, 1);
      cyc(1, 8'h01, pat(11), 1, 8'h01, pat(21), 0, 0, 1, 0);
      cyc(1, 8'h02, pat(12), 1, 8'h01, pat(21), 0, 0, 0, 1);
      idle(1);
      chk("rr_cnt0", DW'(c0), DW'(3));
      chk("rr_cnt1", DW'(c1), DW'(3));

      // clear wins over a valid req1; a second pulse mid-clear is ignored
      cyc(0, 8'h0, '0, 1, 8'h07, pat(30), 1, 0, 0, 0);
      for (int k = 1; k <= 512; k++) begin
         sb.push_back('{AW'(k - 1), '0});
         cyc(0, 8'h0, '0, 1, 8'h07, pat(30),
             (k == 100), 0, 0, 0);
         chk("clr_busy", DW'(busy), DW'(1));
         if (k == 1) begin
            chk("clr_cnt0", DW'(c0), '0);
            chk("clr_cnt1", DW'(c1), '0);
         end
      end
      cyc(0, 8'h0, '0, 1, 8'h07, pat(30), 0, 0, 0, 1);
      chk("clr_done", DW'(done), DW'(1));
      chk("clr_busy_end", DW'(busy), '0);
      chk("clr_sb", DW'(sb.size()), DW'(1));
      idle(1);
      chk("clr_done_once", DW'(done), '0);
      chk("post_cnt0", DW'(c0), '0);
      chk("post_cnt1", DW'(c1), DW'(1));

      // reset during clear cycle 50 aborts the fill
      cyc(0, 8'h0, '0, 0, 8'h0, '0, 1, 0, 0, 0);
      for (int k = 1; k <= 50; k++) begin
         sb.push_back('{AW'(k - 1), '0});
         cyc(0, 8'h0, '0, 0, 8'h0, '0, 0, (k == 50), 0, 0);
      end
      idle(1);
      chk("abort_wr_en", DW'(bif.o_bram_wr_en), '0);
      chk("abort_busy", DW'(busy), '0);
      chk("abort_done", DW'(done), '0);
      chk("abort_cnt0", DW'(c0), '0);
      chk("abort_cnt1", DW'(c1), '0);
      chk("abort_sb", DW'(sb.size()), '0);
      idle(1);
      chk("abort_done2", DW'(done), '0);
      chk("abort_wr_en2", DW'(bif.o_bram_wr_en), '0);

      for (int i = 0; i < 600; i++) begin
         cyc(1, 8'(i), pat(1000 + i), 0, 8'h0, '0, 0, 0, 1, 0);
         chk("sat_cnt0", DW'(c0), DW'((i > 511) ? 511 : i));
      end
      idle(1);
      chk("sat_final0", DW'(c0), DW'(511));
      chk("sat_final1", DW'(c1), '0);

      idle(2);
      chk("sb_empty", DW'(sb.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/result_bram_wr_arbiter.md
RESULT_BRAM_WR_ARBITER -- requirements
Module: result_bram_wr_arbiter

Interface
REQ-001 Parameter: DATA_W, 256, BRAM line width (16 x FP16).
REQ-002 Parameter: ADDR_W, 9, BRAM line address width (512 lines).
REQ-003 Port: i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: i_reset  input  1  reset, synchronous, active-high.
REQ-005 Port: i_req0_valid  input  1  requester 0 (engine 0 packer) has a line to write.
REQ-006 Port: o_req0_ready  output  1  requester 0 line accepted this cycle when valid & ready.
REQ-007 Port: i_req0_idx  input  8  requester 0 line index within its region.
REQ-008 Port: i_req0_data  input  DATA_W  requester 0 line data.
REQ-009 Port: i_req1_valid, o_req1_ready, i_req1_idx, i_req1_data  same directions/widths as REQ-005..008, requester 1 (engine 1 packer).
REQ-010 Port: i_clear_start  input  1  single-cycle pulse requesting a zero-fill of the whole BRAM.
REQ-011 Port: o_clear_busy  output  1  high while zero-fill is in progress.
REQ-012 Port: o_clear_done  output  1  one-cycle pulse when zero-fill completes.
REQ-013 Port: o_bram_wr_en  output  1  BRAM write strobe.
REQ-014 Port: o_bram_wr_addr  output  ADDR_W  BRAM write line address.
REQ-015 Port: o_bram_wr_data  output  DATA_W  BRAM write data.
REQ-016 Port: o_wr_count0, o_wr_count1  output  9  lines written per requester since reset or last clear.

Function
REQ-017 States SHALL be ARB and CLEAR; reset state ARB.
REQ-018 In ARB, at most one requester SHALL be granted per cycle; o_reqN_ready is combinational = (state==ARB) & !i_clear_start & grant_N.
REQ-019 Grant: single valid requester wins; both valid -> round-robin pointer selects; pointer SHALL flip to the other requester after every accepted write; pointer reset value selects requester 0.
REQ-020 Ready SHALL never be asserted to a requester whose valid is low.
REQ-021 Accepted line SHALL appear on BRAM port the following cycle: wr_en=1, addr={N[0], idx[7:0]} (req0 -> 0..255, req1 -> 256..511), data=accepted data.
REQ-022 o_bram_wr_en SHALL be low in any cycle following a cycle with no acceptance and no clear write; addr/data hold last value when wr_en low.
REQ-023 o_wr_countN SHALL increment by 1 on each accepted requester-N line, saturating at 9'h1FF.
REQ-024 i_clear_start in ARB SHALL win over any simultaneous valid (no grant that cycle), move to CLEAR, zero both counters, and set o_clear_busy next cycle.
REQ-025 In CLEAR, one zero write per cycle SHALL issue to addresses 0,1,...,511 in order (512 consecutive wr_en cycles, data all zeros); both readies low throughout.
REQ-026 The cycle after the write to address 511, state SHALL return to ARB, o_clear_busy deassert and o_clear_done pulse for exactly one cycle; grants may resume that same cycle.
REQ-027 i_clear_start while in CLEAR SHALL be ignored (no restart, no extension).
REQ-028 Round-robin pointer SHALL be unchanged by a clear operation.

Reset
REQ-029 On i_reset high at a clock edge: state ARB, pointer=req0, o_bram_wr_en=0, o_bram_wr_addr=0, o_bram_wr_data=0, o_clear_busy=0, o_clear_done=0, both counts=0; readies combinationally low while reset asserted.
REQ-030 Reset asserted mid-clear SHALL abort the zero-fill immediately with no further writes and no o_clear_done pulse.

Verification
REQ-031 Only req0 valid, idx=8'h05, data=D -> ready0 same cycle; next cycle wr_en=1, addr=9'h005, data=D; count0=1.
REQ-032 Both valid for 4 cycles (req0 idx 0..1, req1 idx 0..1) -> grants 0,1,0,1; addresses 0x000,0x100,0x001,0x101 on consecutive cycles.
REQ-033 clear_start coincident with req1 valid -> no ready that cycle; 512 zero writes addr 0..511; done pulse one cycle after addr 511; then req1 granted; counts 0 then 1.
REQ-034 clear_start pulsed again at clear cycle 100 -> total zero writes still exactly 512, single done pulse.
REQ-035 Reset at clear cycle 50 -> wr_en low next cycle, busy=0, no done pulse, counts 0.
REQ-036 req0 sends 600 lines -> count0 saturates at 511; BRAM addresses wrap within 0..255 per idx.
